// File: rtl/seg_sequencer.sv
// Up/down state sequencer with prescaler, synchronous saturating load and a
// seven-segment decode of the current state. Optional build macro:
// SEG_SEQUENCER_DP_WRAP_EN adds a decimal-point register toggled on every wrap.
module seg_sequencer #(
    parameter int NSTATES  = 4,
    parameter int PRESCALE = 1
) (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] state_o,
    output logic [7:0] SEG,
    output logic       wrap
);

    localparam logic [3:0]  STATE_MAX = 4'(NSTATES - 1);
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            4'hF:    p = 7'h71;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    logic [3:0]  state_r;
    logic [3:0]  state_next_s;
    logic [15:0] presc_r;
    logic [15:0] presc_next_s;
    logic        wrap_r;
    logic        wrap_next_s;
    logic        tick_s;
    logic        dp_s;

    // Next-state decode: load beats the tick, a disabled cycle freezes everything.
    always_comb begin
        state_next_s = state_r;
        presc_next_s = presc_r;
        wrap_next_s  = 1'b0;
        tick_s       = enable && (presc_r == PRESC_MAX);
        if (load) begin
            state_next_s = (load_val > STATE_MAX) ? STATE_MAX : load_val;
            presc_next_s = 16'd0;
        end else if (tick_s) begin
            presc_next_s = 16'd0;
            if (!dir) begin
                if (state_r >= STATE_MAX) begin
                    state_next_s = 4'd0;
                    wrap_next_s  = 1'b1;
                end else begin
                    state_next_s = state_r + 4'd1;
                end
            end else begin
                if (state_r == 4'd0) begin
                    state_next_s = STATE_MAX;
                    wrap_next_s  = 1'b1;
                end else begin
                    state_next_s = state_r - 4'd1;
                end
            end
        end else if (enable) begin
            presc_next_s = presc_r + 16'd1;
        end else begin
            presc_next_s = presc_r;
        end
    end

    // State, prescaler and wrap pulse registers.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= 4'd0;
            presc_r <= 16'd0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            presc_r <= presc_next_s;
            wrap_r  <= wrap_next_s;
        end
    end

`ifdef SEG_SEQUENCER_DP_WRAP_EN
    logic dp_r;

    // Decimal point flips on the same edge the wrapped state is loaded.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            dp_r <= 1'b0;
        end else if (wrap_next_s) begin
            dp_r <= ~dp_r;
        end else begin
            dp_r <= dp_r;
        end
    end

    assign dp_s = dp_r;
`else
    assign dp_s = 1'b0;
`endif

    assign state_o = state_r;
    assign wrap    = wrap_r;
    assign SEG     = {dp_s, seg_decode(state_r)};

endmodule

// File: tb/tb_seg_sequencer.sv
// Self-checking bench for seg_sequencer: three instances (4/1, 10/3, 2/1)
// share stimulus and are compared against an arithmetic reference model.
module tb_seg_sequencer;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       dir;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] st  [3];
    logic [7:0] seg [3];
    logic       wr  [3];

    int n_checks = 0;
    int n_fail   = 0;

    int         ns_a    [3];
    int         ps_a    [3];
    int         m_state [3];
    int         m_presc [3];
    logic       m_wrap  [3];
    logic       m_dp    [3];
    logic [6:0] seg_tbl [16];

    always #5 clk_2 = ~clk_2;

    seg_sequencer #(.NSTATES(4), .PRESCALE(1)) u_a (
        .clk_2(clk_2), .rst_n(rst_n), .enable(enable), .dir(dir), .load(load),
        .load_val(load_val), .state_o(st[0]), .SEG(seg[0]), .wrap(wr[0]));
    seg_sequencer #(.NSTATES(10), .PRESCALE(3)) u_b (
        .clk_2(clk_2), .rst_n(rst_n), .enable(enable), .dir(dir), .load(load),
        .load_val(load_val), .state_o(st[1]), .SEG(seg[1]), .wrap(wr[1]));
    seg_sequencer #(.NSTATES(2), .PRESCALE(1)) u_c (
        .clk_2(clk_2), .rst_n(rst_n), .enable(enable), .dir(dir), .load(load),
        .load_val(load_val), .state_o(st[2]), .SEG(seg[2]), .wrap(wr[2]));

    function automatic logic dp_exp(input int i);
`ifdef SEG_SEQUENCER_DP_WRAP_EN
        return m_dp[i];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_state[i] = 0; m_presc[i] = 0; m_wrap[i] = 1'b0; m_dp[i] = 1'b0;
        end
    endtask

    // Reference behaviour for one rising edge, from the current input values.
    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            m_wrap[i] = 1'b0;
            if (load) begin
                m_state[i] = (int'(load_val) < ns_a[i]) ? int'(load_val) : ns_a[i] - 1;
                m_presc[i] = 0;
            end else if (enable) begin
                if (m_presc[i] == ps_a[i] - 1) begin
                    int nxt;
                    m_presc[i] = 0;
                    nxt = dir ? (m_state[i] + ns_a[i] - 1) % ns_a[i] : (m_state[i] + 1) % ns_a[i];
                    m_wrap[i] = dir ? (m_state[i] == 0) : (nxt == 0);
                    if (m_wrap[i]) m_dp[i] = ~m_dp[i];
                    m_state[i] = nxt;
                end else begin
                    m_presc[i] = m_presc[i] + 1;
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic d, input logic ld, input logic [3:0] lv);
        enable = en; dir = d; load = ld; load_val = lv;
        @(posedge clk_2);
        model_clock();
        @(negedge clk_2);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk_2);
        @(negedge clk_2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (st[i] !== 4'd0 || seg[i] !== 8'h3F || wr[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst=%0d got st=%0d seg=%h wrap=%b exp st=0 seg=3f wrap=0",
                         i, st[i], seg[i], wr[i]);
            end
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_st  [5] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        logic [7:0] exp_seg [5] = '{8'h06, 8'h5B, 8'h4F, 8'h3F, 8'h06};
        logic       exp_wr  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0);
            n_checks++;
            if (st[0] !== exp_st[c] || seg[0][6:0] !== exp_seg[c][6:0] || wr[0] !== exp_wr[c]) begin
                n_fail++;
                $display("FAIL count_up cyc=%0d got st=%0d seg=%h wrap=%b exp st=%0d seg=%h wrap=%b",
                         c, st[0], seg[0], wr[0], exp_st[c], exp_seg[c], exp_wr[c]);
            end
        end
    endtask

    task automatic test_count_down_wrap();
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (st[0] !== 4'd3 || seg[0][6:0] !== 7'h4F || wr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap got st=%0d seg=%h wrap=%b exp st=3 seg=4f wrap=1", st[0], seg[0], wr[0]);
        end
        step(1'b0, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (st[0] !== 4'd3 || wr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL down_wrap_pulse got st=%0d wrap=%b exp st=3 wrap=0", st[0], wr[0]);
        end
    endtask

    task automatic test_load_saturate();
        step(1'b1, 1'b0, 1'b1, 4'd12);
        n_checks++;
        if (st[1] !== 4'd9 || seg[1][6:0] !== 7'h6F || wr[1] !== 1'b0 || st[0] !== 4'd3) begin
            n_fail++;
            $display("FAIL load_sat got st=%0d seg=%h wrap=%b st4=%0d exp st=9 seg=6f wrap=0 st4=3",
                     st[1], seg[1], wr[1], st[0]);
        end
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (st[1] !== 4'd9 || wr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_presc got st=%0d wrap=%b exp st=9 wrap=0", st[1], wr[1]);
        end
        step(1'b1, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (st[1] !== 4'd0 || wr[1] !== 1'b1 || seg[1][6:0] !== 7'h3F) begin
            n_fail++;
            $display("FAIL load_then_wrap got st=%0d wrap=%b seg=%h exp st=0 wrap=1 seg=3f", st[1], wr[1], seg[1]);
        end
    endtask

    task automatic test_prescale_pause();
        logic       en_seq [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_st [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int c = 0; c < 8; c++) begin
            step(en_seq[c], 1'b0, 1'b0, 4'd0);
            n_checks++;
            if (st[1] !== exp_st[c]) begin
                n_fail++;
                $display("FAIL prescale_pause cyc=%0d got st=%0d exp st=%0d", c, st[1], exp_st[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b1, 4'd2);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (st[1] !== 4'd0 || seg[1] !== 8'h3F || wr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got st=%0d seg=%h wrap=%b exp st=0 seg=3f wrap=0", st[1], seg[1], wr[1]);
        end
        model_reset();
        @(negedge clk_2);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0);
            n_checks++;
            if (st[1] !== ((c == 2) ? 4'd1 : 4'd0)) begin
                n_fail++;
                $display("FAIL post_reset_presc cyc=%0d got st=%0d exp st=%0d", c, st[1], (c == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_dp_wrap();
        logic [3:0] exp_st [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
`ifdef SEG_SEQUENCER_DP_WRAP_EN
        logic       exp_dp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        logic       exp_dp [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        enable = 1'b0; load = 1'b0;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0);
            n_checks++;
            if (st[2] !== exp_st[c] || seg[2][7] !== exp_dp[c]) begin
                n_fail++;
                $display("FAIL dp_wrap cyc=%0d got st=%0d dp=%b exp st=%0d dp=%b",
                         c, st[2], seg[2][7], exp_st[c], exp_dp[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 3) != 0), (($urandom & 32'd7) == 32'd0) ? ~dir : dir,
                 ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (int'(st[i]) != m_state[i] || wr[i] !== m_wrap[i] ||
                    seg[i] !== {dp_exp(i), seg_tbl[m_state[i]]}) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d inst=%0d got st=%0d seg=%h wrap=%b exp st=%0d seg=%h wrap=%b",
                             c, i, st[i], seg[i], wr[i], m_state[i],
                             {dp_exp(i), seg_tbl[m_state[i]]}, m_wrap[i]);
                end
            end
        end
    endtask

    initial begin
        ns_a = '{4, 10, 2};
        ps_a = '{1, 3, 1};
        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst_n = 1'b0;
        test_reset();
        test_count_up();
        test_count_down_wrap();
        test_load_saturate();
        test_prescale_pause();
        test_async_reset();
        test_dp_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_sequencer.md
SEG_SEQUENCER -- requirements
Module: seg_sequencer

Interface
REQ-001 Parameter NSTATES, default 4: number of sequence states; legal range 2..16.
REQ-002 Parameter PRESCALE, default 1: enabled clock cycles per step; legal range 1..65535.
REQ-003 clk_2  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  1 = advance one step per prescaler tick; 0 = hold.
REQ-006 dir  input  1  0 = count up, 1 = count down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  4  state value applied when load=1.
REQ-009 state_o  output  4  current state index.
REQ-010 SEG  output  8  seven-segment pattern: bits [6:0] = gfedcba, active-high; bit [7] = decimal point.
REQ-011 wrap  output  1  one-cycle pulse on each wrap-around step.

Function
REQ-012 State register holds 0..NSTATES-1; the value is never outside this range.
REQ-013 Prescaler counts enabled cycles 0..PRESCALE-1; a tick is generated on the cycle it equals PRESCALE-1, and the counter then returns to 0.
REQ-014 When PRESCALE=1, every cycle with enable=1 is a tick.
REQ-015 enable=0: prescaler and state hold their values; wrap=0.
REQ-016 On a tick with dir=0: state <= state+1, or 0 if state=NSTATES-1.
REQ-017 On a tick with dir=1: state <= state-1, or NSTATES-1 if state=0.
REQ-018 wrap is registered and asserted in the cycle the state takes its wrapped value (0 going up, NSTATES-1 going down); it stays asserted for exactly one cycle.
REQ-019 load=1 has priority over enable and over the tick: state <= min(load_val, NSTATES-1), prescaler <= 0, wrap <= 0.
REQ-020 A dir change in the middle of a prescale period does not reset the prescaler; it applies at the next tick.
REQ-021 SEG[6:0] is a combinational decode of the state register, with zero added latency after the state update. Hex codes 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-022 state_o mirrors the state register, zero-extended to 4 bits.

Reset
REQ-023 When rst_n=0, asynchronously set: state=0, prescaler=0, wrap=0, decimal-point register=0. Consequently SEG=8'h3F.
REQ-024 Reset asserted mid-prescale or mid-wrap cancels the pending step and the wrap pulse.
REQ-025 After rst_n deasserts, the first tick needs a full PRESCALE enabled cycles.

Configuration
REQ-026 Macro SEG_SEQUENCER_DP_WRAP_EN.
  - Defined: a decimal-point register toggles on every wrap event and drives SEG[7].
  - Undefined: SEG[7] is tied to 0 and the register is not instantiated.
  - All other behaviour is identical in both builds.

Verification
REQ-027 NSTATES=4, PRESCALE=1, enable=1, dir=0, for 5 cycles after reset -> state_o 1,2,3,0,1; SEG 06,5B,4F,3F,06; wrap high only on the cycle state_o=0.
REQ-028 NSTATES=4, state=0, dir=1, one tick -> state_o=3, SEG=4F, wrap pulses once.
REQ-029 NSTATES=10, load=1 with load_val=12 while enable=1 -> state_o=9, SEG=6F, wrap=0; next tick with dir=0 -> state_o=0, wrap=1.
REQ-030 PRESCALE=3, enable=1: state_o increments every 3rd cycle. Drop enable for 2 cycles after the 1st prescaler cycle -> the step is delayed by exactly 2 cycles.
REQ-031 rst_n pulsed low between clock edges at state 2 with a tick pending -> state_o=0, SEG=3F, wrap=0 immediately, with no clock edge needed.
REQ-032 With SEG_SEQUENCER_DP_WRAP_EN, NSTATES=2, PRESCALE=1, 4 ticks up -> SEG[7] toggles 0->1->0 on the two wraps. Without the macro -> SEG[7]=0 throughout.
